// File: rtl/mlp_fwd_pkg.sv
// Shared types and helpers for the MLP forward engine.
//   state_t       : controller states (IDLE, L2, ACT2, L3, DONE)
//   acc_w()       : accumulator width that cannot overflow for given sizes
//   b2/w3/b3_base : start addresses of each parameter bank in the write map
//   relu(), sat() : activation and clamp on a 64-bit signed intermediate
// The 64-bit intermediate assumes the accumulator width stays below 64 bits.
package mlp_fwd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_L2   = 3'd1,
        ST_ACT2 = 3'd2,
        ST_L3   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic int acc_w(input int n_in, input int n_hid, input int dw);
        int m;
        m = (n_in > n_hid) ? n_in : n_hid;
        return 2 * dw + $clog2(m) + 1;
    endfunction

    function automatic int b2_base(input int n_in, input int n_hid);
        return n_in * n_hid;
    endfunction

    function automatic int w3_base(input int n_in, input int n_hid);
        return n_in * n_hid + n_hid;
    endfunction

    function automatic int b3_base(input int n_in, input int n_hid, input int n_out);
        return n_in * n_hid + n_hid + n_hid * n_out;
    endfunction

    function automatic logic signed [63:0] relu(input logic signed [63:0] v);
        return (v < 64'sd0) ? 64'sd0 : v;
    endfunction

    // Clamp to the signed range of a dw-bit word.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/mlp_fwd_engine_mac_lane.sv
// mac_lane: one signed multiply-accumulate lane.
//   clk, rst   : rising-edge clock, asynchronous active-low reset
//   clr        : start from zero instead of the held sum
//   en         : add a*b this cycle
//   a, b       : signed DW-bit operands
//   acc_d      : next accumulator value (the value registered at this edge)
// Exposing the next value lets the caller capture a final sum on the same
// edge that adds the last product.
module mac_lane #(
    parameter int DW    = 16,
    parameter int ACC_W = 37
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [DW-1:0]    a,
    input  logic signed [DW-1:0]    b,
    output logic signed [ACC_W-1:0] acc_d
);

    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  prod_x;
    logic signed [ACC_W-1:0]  base;
    logic signed [2*DW-1:0]   ax;
    logic signed [2*DW-1:0]   bx;
    logic signed [2*DW-1:0]   prod;

    always_comb begin
        // Sign-extend first; the low 2*DW bits of the product are then exact.
        ax     = $signed({{DW{a[DW-1]}}, a});
        bx     = $signed({{DW{b[DW-1]}}, b});
        prod   = ax * bx;
        prod_x = $signed({{(ACC_W-2*DW){prod[2*DW-1]}}, prod});
        base   = clr ? '0 : acc_q;
        acc_d  = en ? (base + prod_x) : base;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) acc_q <= '0;
        else      acc_q <= acc_d;
    end

endmodule

// File: rtl/mlp_fwd_engine.sv
// mlp_fwd_engine: two-layer perceptron forward pass with ReLU hidden layer,
// optional ReLU output, saturating fixed point and greedy action output.
//   clk, rst             : rising-edge clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data: parameter write port, honoured only in IDLE
//   in_valid/in_ready    : input stream, one feature per beat, index 0 first
//   in_data              : signed feature value
//   out_valid/out_ready  : result handshake; a2, q, action held while waiting
//   a2, q                : packed hidden and output activations
//   action               : index of the largest q (lowest index on ties)
//   busy                 : controller is not in IDLE
//   dbg_state            : current controller state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and a held result stays stable.
module mlp_fwd_engine
    import mlp_fwd_pkg::*;
#(
    parameter int N_IN    = 9,
    parameter int N_HID   = 5,
    parameter int N_OUT   = 4,
    parameter int DW      = 16,
    parameter int FRAC    = 8,
    parameter int ACT_OUT = 0,
    localparam int NW     = N_IN * N_HID + N_HID + N_HID * N_OUT + N_OUT,
    localparam int AW     = $clog2(NW),
    localparam int AXW    = (N_OUT > 2) ? $clog2(N_OUT) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic signed [DW-1:0]   wr_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [DW-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_HID*DW-1:0]    a2,
    output logic [N_OUT*DW-1:0]    q,
    output logic [AXW-1:0]         action,
    output logic                   busy,
    output state_t                 dbg_state
);

    localparam int ACC_W = acc_w(N_IN, N_HID, DW);
    localparam int B2    = b2_base(N_IN, N_HID);
    localparam int W3    = w3_base(N_IN, N_HID);
    localparam int B3    = b3_base(N_IN, N_HID, N_OUT);
    localparam int CW    = $clog2(((N_IN > N_HID) ? N_IN : N_HID) + 1);

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic signed [DW-1:0]    prm    [NW];
    logic signed [DW-1:0]    a2_r   [N_HID];
    logic signed [DW-1:0]    q_r    [N_OUT];
    logic signed [ACC_W-1:0] hacc   [N_HID];
    logic signed [ACC_W-1:0] oacc   [N_OUT];
    logic signed [DW-1:0]    hid_w  [N_HID];
    logic signed [DW-1:0]    out_w  [N_OUT];
    logic signed [DW-1:0]    a2_nxt [N_HID];
    logic signed [DW-1:0]    q_nxt  [N_OUT];
    logic signed [DW-1:0]    a2_sel;
    logic [AXW-1:0]          act_nxt;
    logic                    hid_clr, hid_en, out_clr, out_en;

    assign in_ready  = (state == ST_IDLE) || (state == ST_L2);
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;
    // Hidden sums restart with the first beat; output sums restart in ACT2.
    assign hid_clr   = (state == ST_IDLE);
    assign hid_en    = in_valid && in_ready;
    assign out_clr   = (state == ST_ACT2);
    assign out_en    = (state == ST_L3);

    // cnt is the input index in IDLE/L2 and the hidden index in L3.
    always_comb begin : weight_select
        for (int h = 0; h < N_HID; h++) hid_w[h] = '0;
        for (int o = 0; o < N_OUT; o++) out_w[o] = '0;
        a2_sel = '0;
        for (int k = 0; k < NW; k++) begin
            for (int h = 0; h < N_HID; h++)
                if (k == int'(cnt) * N_HID + h) hid_w[h] = prm[k];
            for (int o = 0; o < N_OUT; o++)
                if (k == W3 + int'(cnt) * N_OUT + o) out_w[o] = prm[k];
        end
        for (int h = 0; h < N_HID; h++)
            if (int'(cnt) == h) a2_sel = a2_r[h];
    end

    for (genvar h = 0; h < N_HID; h++) begin : g_hid
        mac_lane #(.DW(DW), .ACC_W(ACC_W)) u_mac (
            .clk(clk), .rst(rst), .clr(hid_clr), .en(hid_en),
            .a(in_data), .b(hid_w[h]), .acc_d(hacc[h])
        );
        assign a2[h*DW +: DW] = a2_r[h];
    end

    for (genvar o = 0; o < N_OUT; o++) begin : g_out
        mac_lane #(.DW(DW), .ACC_W(ACC_W)) u_mac (
            .clk(clk), .rst(rst), .clr(out_clr), .en(out_en),
            .a(a2_sel), .b(out_w[o]), .acc_d(oacc[o])
        );
        assign q[o*DW +: DW] = q_r[o];
    end

    // Bias is aligned to the product scale, then the sum is floored back
    // to FRAC fractional bits before activation and clamping.
    always_comb begin : act_calc
        logic signed [63:0] s;
        logic signed [DW-1:0] best;
        s       = '0;
        best    = '0;
        act_nxt = '0;
        for (int h = 0; h < N_HID; h++) begin
            s = $signed({{(64-ACC_W){hacc[h][ACC_W-1]}}, hacc[h]});
            s = s + ($signed({{(64-DW){prm[B2+h][DW-1]}}, prm[B2+h]}) <<< FRAC);
            s = s >>> FRAC;
            s = sat(relu(s), DW);
            a2_nxt[h] = s[DW-1:0];
        end
        for (int o = 0; o < N_OUT; o++) begin
            s = $signed({{(64-ACC_W){oacc[o][ACC_W-1]}}, oacc[o]});
            s = s + ($signed({{(64-DW){prm[B3+o][DW-1]}}, prm[B3+o]}) <<< FRAC);
            s = s >>> FRAC;
            if (ACT_OUT != 0) s = relu(s);
            s = sat(s, DW);
            q_nxt[o] = s[DW-1:0];
        end
        // Strict greater-than keeps the lowest index on ties.
        best = q_nxt[0];
        for (int o = 1; o < N_OUT; o++) begin
            if (q_nxt[o] > best) begin
                best    = q_nxt[o];
                act_nxt = AXW'(o);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NW; k++) prm[k] <= '0;
        end else if (wr_en && (state == ST_IDLE) && (32'(wr_addr) < NW)) begin
            prm[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            action    <= '0;
            for (int h = 0; h < N_HID; h++) a2_r[h] <= '0;
            for (int o = 0; o < N_OUT; o++) q_r[o] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (N_IN == 1) begin
                            state <= ST_ACT2;
                        end else begin
                            state <= ST_L2;
                            cnt   <= CW'(1);
                        end
                    end
                end
                ST_L2: begin
                    if (in_valid) begin
                        if (cnt == CW'(N_IN - 1)) begin
                            state <= ST_ACT2;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ST_ACT2: begin
                    for (int h = 0; h < N_HID; h++) a2_r[h] <= a2_nxt[h];
                    cnt   <= '0;
                    state <= ST_L3;
                end
                ST_L3: begin
                    if (cnt == CW'(N_HID - 1)) begin
                        // q_nxt already includes the product added at this edge.
                        for (int o = 0; o < N_OUT; o++) q_r[o] <= q_nxt[o];
                        action    <= act_nxt;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_fwd_engine.sv
// Bench for mlp_fwd_engine at default sizes (9-5-4, Q8.8, linear output).
module tb_mlp_fwd_engine;
  import mlp_fwd_pkg::*;

  localparam int N_IN  = 9;
  localparam int N_HID = 5;
  localparam int N_OUT = 4;
  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int NW    = 74;
  localparam int AW    = 7;
  localparam int AXW   = 2;
  localparam int B2    = 45;
  localparam int W3    = 50;
  localparam int B3    = 70;
  localparam int W     = N_HID*DW + N_OUT*DW + AXW;

  typedef int a2v_t[N_HID];
  typedef int qv_t[N_OUT];

  logic                  clk;
  logic                  rst;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic signed [DW-1:0]  wr_data;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [DW-1:0]  in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [N_HID*DW-1:0]   a2;
  logic [N_OUT*DW-1:0]   q;
  logic [AXW-1:0]        action;
  logic                  busy;
  state_t                dbg_state;

  int total;
  int bad;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  mlp_fwd_engine #(
    .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC), .ACT_OUT(0)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .a2(a2), .q(q), .action(action), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // scoreboard
  task automatic push_exp(input a2v_t av, input qv_t qv, input int act);
    logic [W-1:0] e;
    e = '0;
    for (int h = 0; h < N_HID; h++) e[h*DW +: DW] = 16'(av[h]);
    for (int o = 0; o < N_OUT; o++) e[N_HID*DW + o*DW +: DW] = 16'(qv[o]);
    e[W-1 -: AXW] = AXW'(act);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result got=%0h exp=none", {action, q, a2});
      end else begin
        mon_e = exp_q.pop_front();
        chk("a2", W'(a2), W'(mon_e[N_HID*DW-1:0]));
        chk("q", W'(q), W'(mon_e[N_HID*DW +: N_OUT*DW]));
        chk("action", W'(action), W'(mon_e[W-1 -: AXW]));
      end
    end
  end

  // drivers (all start and end 1 time unit after a rising edge)
  task automatic wr(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = 16'(data);
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  task automatic load_uniform(input int w2v, input int w3v);
    for (int k = 0; k < B2; k++) wr(k, w2v);
    for (int k = B2; k < W3; k++) wr(k, 0);
    for (int k = W3; k < B3; k++) wr(k, w3v);
    for (int k = B3; k < NW; k++) wr(k, 0);
  endtask

  task automatic beat(input int v);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'(v);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!got) chk("in_ready_timeout", 0, 1);
  endtask

  // gap_write: after beat 0, idle one cycle while writing w2[0][0]=0
  task automatic send(input int v, input bit gap_write);
    for (int i = 0; i < N_IN; i++) begin
      beat(v);
      if (i == 0 && gap_write) begin
        chk("busy_at_write", W'(busy), 1);
        wr(0, 0);
      end
    end
  endtask

  task automatic wait_valid(output int n);
    bit ok;
    ok = 1'b0;
    n  = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        n  = k;
        break;
      end
    end
    if (!ok) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain", W'(exp_q.size()), 0);
  endtask

  // stimulus
  initial begin
    int n;
    logic [N_OUT*DW-1:0] q_hold;
    total = 0;
    bad = 0;
    rst = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_busy", W'(busy), 0);
    chk("rst_in_ready", W'(in_ready), 1);
    chk("rst_outputs", W'({action, q, a2}), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // all ones (Q8.8): a2 = 9.0, q = 45.0, tie -> action 0, latency t+7
    load_uniform(256, 256);
    push_exp('{2304, 2304, 2304, 2304, 2304}, '{11520, 11520, 11520, 11520}, 0);
    send(256, 0);
    wait_valid(n);
    chk("latency", W'(n), W'(N_HID + 2));
    @(posedge clk); #1;
    drain();

    // negative column 0 -> ReLU; doubled column 2 -> action 2; output stall
    for (int i = 0; i < N_IN; i++) wr(i*N_HID + 0, -256);
    for (int h = 0; h < N_HID; h++) wr(W3 + h*N_OUT + 2, 512);
    push_exp('{0, 2304, 2304, 2304, 2304}, '{9216, 9216, 18432, 9216}, 2);
    out_ready = 1'b0;
    send(256, 0);
    wait_valid(n);
    @(posedge clk); #1;
    q_hold = {16'd9216, 16'd18432, 16'd9216, 16'd9216};
    in_valid = 1'b1;
    in_data = 16'd256;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_out_valid", W'(out_valid), 1);
      chk("stall_q", W'(q), W'(q_hold));
      chk("stall_action", W'(action), 2);
      chk("stall_in_ready", W'(in_ready), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("idle_after_stall", W'(busy), 0);

    // biases: b2[1]=1.0, b3[3]=10000 -> action 3
    wr(B2 + 1, 256);
    wr(B3 + 3, 10000);
    push_exp('{0, 2560, 2304, 2304, 2304}, '{9472, 9472, 18944, 19472}, 3);
    send(256, 0);
    drain();

    // tiny inputs, w3[.][1]=-1: q1 = floor(-292/256) = -2
    for (int h = 0; h < N_HID; h++) wr(W3 + h*N_OUT + 1, -1);
    push_exp('{0, 265, 9, 9, 9}, '{292, -2, 584, 10292}, 3);
    send(1, 0);
    drain();

    // saturation both ways
    load_uniform(32767, -32767);
    push_exp('{32767, 32767, 32767, 32767, 32767}, '{-32768, -32768, -32768, -32768}, 0);
    send(32767, 0);
    drain();

    // write to w2[0][0] while busy is dropped
    load_uniform(256, 256);
    push_exp('{2304, 2304, 2304, 2304, 2304}, '{11520, 11520, 11520, 11520}, 0);
    send(256, 1);
    drain();
    push_exp('{2304, 2304, 2304, 2304, 2304}, '{11520, 11520, 11520, 11520}, 0);
    send(256, 0);
    drain();

    // reset during L3, then rerun with cleared parameters
    send(256, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("in_l3", W'(dbg_state), W'(ST_L3));
    rst = 1'b0;
    #1;
    chk("midrst_a2", W'(a2), 0);
    chk("midrst_q", W'(q), 0);
    chk("midrst_action", W'(action), 0);
    chk("midrst_out_valid", W'(out_valid), 0);
    chk("midrst_busy", W'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    push_exp('{0, 0, 0, 0, 0}, '{0, 0, 0, 0}, 0);
    send(256, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mlp_fwd_engine.md
# mlp_fwd_engine

Parametrised forward-propagation engine for the DQN two-layer perceptron: N_IN serial inputs → N_HID ReLU hidden neurons → N_OUT Q-value outputs plus greedy action index. Weights and biases live in internal register banks, loaded through a word-addressed write port. Inputs arrive on a valid/ready stream; results leave on a valid/ready handshake. It generalises the fixed 9-5-4 forward path to any layer sizes, and adds saturating fixed-point arithmetic, backpressure and an argmax action output.

## Interface
- N_IN, 9, input features (≥1)
- N_HID, 5, hidden neurons (≥1)
- N_OUT, 4, output neurons / actions (≥2)
- DW, 16, signed data width, all operands
- FRAC, 8, fractional bits (Q(DW-FRAC).FRAC)
- ACT_OUT, 0, output activation: 0 linear, 1 ReLU
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-low
- wr_en  in  1  parameter write strobe
- wr_addr  in  AW=clog2(N_IN·N_HID+N_HID+N_HID·N_OUT+N_OUT)  word address
- wr_data  in  DW  signed parameter value
- in_valid / in_ready  in / out  1  input-stream handshake
- in_data  in  DW  one input feature per beat, index 0 first
- out_valid / out_ready  out / in  1  result handshake
- a2  out  N_HID·DW  hidden activations, neuron h at [h·DW +: DW]
- q  out  N_OUT·DW  output activations, neuron o at [o·DW +: DW]
- action  out  max(1,clog2(N_OUT))  index of the largest q
- busy  out  1  high in any state other than IDLE

## Operation
- Address map: w2[i][h] @ i·N_HID+h; b2[h] @ base B2=N_IN·N_HID; w3[h][o] @ base W3=B2+N_HID, offset h·N_OUT+o; b3[o] @ base B3=W3+N_HID·N_OUT. Addresses beyond the map are ignored.
- Writes take effect only in IDLE; they are silently dropped while busy.
- FSM states: IDLE, L2, ACT2, L3, DONE.
  - IDLE: in_ready=1. The first accepted beat clears the accumulators, loads in·w2[0][h] for each h, and moves to L2 (cnt=1). If N_IN=1, it goes directly to ACT2.
  - L2: in_ready=1. Each accepted beat i adds in·w2[i][h] to acc_h. Gaps in in_valid hold state. After beat N_IN-1 → ACT2.
  - ACT2: in_ready=0. a2[h] = sat(ReLU((acc_h + (b2[h]<<FRAC)) >>> FRAC)), registered. Output accumulators are cleared. → L3.
  - L3: one hidden index per cycle, h=0..N_HID-1; acc_o += a2[h]·w3[h][o] for all o in parallel. After h=N_HID-1 → DONE, where q and action are registered on entry.
  - DONE: out_valid=1. a2, q and action are held stable until out_ready=1, then → IDLE.
- Arithmetic: products are 2·DW bits. The accumulator is ACC_W=2·DW+clog2(max(N_IN,N_HID))+1, so no internal overflow is possible. The bias is sign-extended and shifted left by FRAC. The shift right is arithmetic (floor). Saturation clamps to [−2^(DW−1), 2^(DW−1)−1].
- Argmax: uses signed comparison; ties resolve to the lowest index.
- Reset: clears all weights, biases, accumulators, a2, q, action, out_valid and busy to 0, and returns the FSM to IDLE, including mid-operation.

## Timing
- Last input beat accepted at edge t: ACT2 at t+1, L3 during t+2 … t+1+N_HID, out_valid high from t+2+N_HID. With default parameters this is t+7.
- Throughput: one inference per N_IN+N_HID+2 cycles minimum (16 cycles at defaults), plus any output stall.
- in_ready is low in ACT2, L3 and DONE. A new inference can be accepted the cycle after the out handshake.
- A write in the same cycle as the first input beat in IDLE is accepted. That beat uses the weight value from before the write.

## Structure
- Package mlp_fwd_pkg: state enum, ACC_W function, sat() and relu() functions, address-base functions.
- One sub-module, mac_lane, instantiated N_HID + N_OUT times: signed multiply-accumulate with clear and enable.

## Test plan
- All w2=256, w3=256, biases 0, nine inputs of 256: a2 all 2304 and q all 11520 at t+7; action=0 because of the tie.
- w2[·][0]=−256, other weights 256, inputs 256: a2[0]=0 (ReLU). With w3[·][2]=512, q[2] doubles and action=2.
- in=32767, w2=32767, N_IN=9: a2 saturates to 32767. With w2=−32767 and ACT_OUT=0, q saturates to −32768.
- out_ready held low for 10 cycles in DONE: out_valid, q and action stay constant, in_ready=0, and no second beat is accepted.
- rst pulsed low during L3: all outputs read 0 immediately. A rerun without reloading weights gives q=0 and action=0.
- Write to w2[0][0] while busy: the write is ignored, and the next inference matches the pre-write result.
